// File: rtl/unpacker.sv
// unpacker: expands a packed activation byte stream into 16-byte words, placing
// bytes on the lanes selected by a 16-bit mask and zero-filling the rest.
module unpacker #(
  parameter int MEM_BW = 128,
  parameter int ADDR_WIDTH_ACT = 14,
  parameter int ADDR_WIDTH_MASKS = 11
) (
  input  logic                        clk,
  input  logic                        arst_n_in,
  input  logic                        start_unpacker,
  input  logic [15:0]                 nb_words,
  output logic                        read_masks_memory,
  output logic [ADDR_WIDTH_MASKS-1:0] masks_addr,
  input  logic [MEM_BW-1:0]           masks_rdata,
  output logic                        read_act_memory,
  output logic [ADDR_WIDTH_ACT-1:0]   act_addr,
  input  logic [MEM_BW-1:0]           act_rdata,
  output logic [MEM_BW-1:0]           decoded_out,
  output logic                        decoded_valid,
  input  logic                        decoded_ready,
  output logic                        done_unpacker
);
  typedef enum logic [2:0] {IDLE, RD_MASK, WAIT_MASK, CHECK, RD_ACT, WAIT_ACT, OUTPUT, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] buffer [32];
  logic [5:0] fill;
  logic [15:0] total, words_done;
  logic [MEM_BW-1:0] mask_word, dec;
  logic [2:0] mask_idx;
  logic [15:0] mask;
  logic [4:0] need;
  // need doubles as the running prefix popcount, i.e. the buffer index of the next set lane
  always_comb begin
    mask = mask_word[MEM_BW-1-16*int'(mask_idx) -: 16];
    need = '0;
    dec = '0;
    for (int b = 0; b < 16; b++) begin
      if (mask[15-b]) begin
        dec[MEM_BW-1-8*b -: 8] = buffer[need];
        need = need + 5'd1;
      end
    end
  end
  always_comb begin
    state_nx = state;
    read_masks_memory = state == RD_MASK;
    read_act_memory = state == RD_ACT;
    decoded_valid = state == OUTPUT;
    decoded_out = state == OUTPUT ? dec : '0;
    done_unpacker = state == DONE;
    case (state)
      IDLE: if (start_unpacker) state_nx = nb_words == 16'd0 ? DONE : RD_MASK;
      RD_MASK: state_nx = WAIT_MASK;
      WAIT_MASK: state_nx = CHECK;
      CHECK: state_nx = fill >= {1'b0, need} ? OUTPUT : RD_ACT;
      RD_ACT: state_nx = WAIT_ACT;
      WAIT_ACT: state_nx = CHECK;
      OUTPUT: if (decoded_ready) state_nx = words_done + 16'd1 == total ? DONE :
                                            mask_idx == 3'd7 ? RD_MASK : CHECK;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state <= IDLE;
      fill <= '0;
      total <= '0;
      words_done <= '0;
      mask_word <= '0;
      mask_idx <= '0;
      masks_addr <= '0;
      act_addr <= '0;
      for (int i = 0; i < 32; i++) buffer[i] <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (start_unpacker) begin
          total <= nb_words;
          words_done <= '0;
          fill <= '0;
          mask_idx <= '0;
          masks_addr <= '0;
          act_addr <= '0;
        end
        WAIT_MASK: begin
          mask_word <= masks_rdata;
          mask_idx <= '0;
          masks_addr <= masks_addr + ADDR_WIDTH_MASKS'(1);
        end
        WAIT_ACT: begin
          for (int i = 0; i < 16; i++) buffer[5'(fill) + 5'(i)] <= act_rdata[MEM_BW-1-8*i -: 8];
          fill <= fill + 6'd16;
          act_addr <= act_addr + ADDR_WIDTH_ACT'(1);
        end
        OUTPUT: if (decoded_ready) begin
          for (int i = 0; i < 32; i++) buffer[i] <= (i + int'(need) < 32) ? buffer[5'(i + int'(need))] : 8'h00;
          fill <= fill - {1'b0, need};
          words_done <= words_done + 16'd1;
          mask_idx <= mask_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_unpacker.sv
// tb_unpacker: directed tests with a byte-stream reference model and per-cycle output checks.
module tb_unpacker;
  logic clk = 0, arst_n = 0, start_unpacker = 0, decoded_ready = 1;
  logic [15:0] nb_words = 0;
  logic read_masks_memory, read_act_memory, decoded_valid, done_unpacker;
  logic [10:0] masks_addr;
  logic [13:0] act_addr;
  logic [127:0] masks_rdata = 0, act_rdata = 0, decoded_out;
  int total = 0, bad = 0;
  logic [127:0] mask_mem [16], act_mem [16];
  logic [15:0] mlist [$];
  logic [7:0] stream [$];
  logic [127:0] exp_q [$], got_q [$];
  int eidx = 0, act_reads = 0, mask_reads = 0, done_cnt = 0, model_bytes = 0;
  int act_log [$], mask_log [$];
  logic stall_prev = 0;
  logic [127:0] prev_out = 0;

  unpacker dut (.clk(clk), .arst_n_in(arst_n), .start_unpacker(start_unpacker), .nb_words(nb_words),
    .read_masks_memory(read_masks_memory), .masks_addr(masks_addr), .masks_rdata(masks_rdata),
    .read_act_memory(read_act_memory), .act_addr(act_addr), .act_rdata(act_rdata),
    .decoded_out(decoded_out), .decoded_valid(decoded_valid), .decoded_ready(decoded_ready),
    .done_unpacker(done_unpacker));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  // memories answer one cycle after the strobe
  always @(posedge clk) begin
    if (read_masks_memory) begin
      mask_reads++;
      mask_log.push_back(int'(masks_addr));
      masks_rdata <= mask_mem[masks_addr[3:0]];
    end
    if (read_act_memory) begin
      act_reads++;
      act_log.push_back(int'(act_addr));
      act_rdata <= act_mem[act_addr[3:0]];
    end
  end

  always @(negedge clk) begin
    if (!arst_n) stall_prev = 0;
    else begin
      if (read_masks_memory && read_act_memory) chk("dual_strobe", 1, 0);
      if (decoded_valid) begin
        if (stall_prev) chk("stable_out", decoded_out, prev_out);
        if (read_masks_memory || read_act_memory) chk("read_in_output", 1, 0);
        if (decoded_ready) begin
          if (eidx < exp_q.size()) chk($sformatf("word%0d", eidx), decoded_out, exp_q[eidx]);
          else chk("extra_word", 1, 0);
          got_q.push_back(decoded_out);
          eidx++;
        end
        stall_prev = !decoded_ready;
        prev_out = decoded_out;
      end else stall_prev = 0;
      if (done_unpacker) done_cnt++;
    end
  end

  // builds memories from mlist/stream and the expected words by walking the byte stream
  task automatic load(input int n);
    int p;
    logic [127:0] w;
    logic [15:0] m;
    for (int a = 0; a < 16; a++) begin
      mask_mem[a] = '0;
      act_mem[a] = '0;
    end
    for (int k = 0; k < mlist.size(); k++) mask_mem[k/8][127-16*(k%8) -: 16] = mlist[k];
    for (int k = 0; k < stream.size(); k++) act_mem[k/16][127-8*(k%16) -: 8] = stream[k];
    exp_q.delete();
    got_q.delete();
    act_log.delete();
    mask_log.delete();
    p = 0;
    for (int k = 0; k < n; k++) begin
      m = mlist[k];
      w = '0;
      for (int b = 0; b < 16; b++)
        if (m[15-b]) begin
          w[127-8*b -: 8] = p < stream.size() ? stream[p] : 8'h00;
          p++;
        end
      exp_q.push_back(w);
    end
    model_bytes = p;
    eidx = 0;
    act_reads = 0;
    mask_reads = 0;
    done_cnt = 0;
  endtask

  task automatic kick(input int n);
    @(posedge clk); #1;
    nb_words = 16'(n);
    start_unpacker = 1;
    @(posedge clk); #1;
    start_unpacker = 0;
  endtask

  task automatic finish_run(input int n, input string tag);
    int c;
    for (c = 0; c < 3000 && !done_unpacker; c++) @(negedge clk);
    if (c == 3000) chk({tag, "_timeout"}, 1, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done_unpacker, 0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_words"}, eidx, n);
    chk({tag, "_act_reads"}, act_reads, (model_bytes + 15) / 16);
    chk({tag, "_mask_reads"}, mask_reads, (n + 7) / 8);
  endtask

  task automatic run(input int n, input string tag);
    load(n);
    kick(n);
    finish_run(n, tag);
  endtask

  task automatic set_stream(input int first, input int len);
    stream.delete();
    for (int i = 0; i < len; i++) stream.push_back(8'(first + i));
  endtask

  initial begin
    int c, r0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", decoded_valid, 0);
    chk("rst_out", decoded_out, 0);
    chk("rst_done", done_unpacker, 0);
    chk("rst_strobes", {read_masks_memory, read_act_memory}, 0);
    chk("rst_addrs", {masks_addr, act_addr}, 0);
    #1 arst_n = 1;

    mlist = '{16'hFFFF};
    set_stream(0, 16);
    run(1, "all_ones");
    chk("all_ones_lit", got_q.size() > 0 ? got_q[0] : 'x, 128'h000102030405060708090a0b0c0d0e0f);
    chk("all_ones_reads_lit", act_reads, 1);

    mlist = '{16'h0000};
    set_stream(8'h55, 16);
    run(1, "zero_mask");
    chk("zero_mask_lit", got_q.size() > 0 ? got_q[0] : 'x, 128'h0);
    chk("zero_mask_no_act", act_reads, 0);

    mlist = '{16'hFF00, 16'hFFF0, 16'hFF00};
    set_stream(8'h10, 32);
    run(3, "straddle");
    chk("straddle_w1_lit", got_q.size() > 1 ? got_q[1] : 'x, 128'h18191a1b1c1d1e1f2021222300000000);
    chk("straddle_w2_lit", got_q.size() > 2 ? got_q[2] : 'x, 128'h2425262728292a2b0000000000000000);
    chk("straddle_reads_lit", act_reads, 2);

    mlist.delete();
    for (int k = 0; k < 8; k++) mlist.push_back(16'h0001);
    mlist.push_back(16'h8000);
    for (int k = 0; k < 7; k++) mlist.push_back(16'hFFFF);
    set_stream(8'hA0, 16);
    run(9, "mask_wrap");
    chk("mask_wrap_w0_lit", got_q.size() > 0 ? got_q[0] : 'x, 128'hA0);
    chk("mask_wrap_w8_lit", got_q.size() > 8 ? got_q[8] : 'x, {8'hA8, 120'h0});
    chk("mask_addr0", mask_log.size() > 0 ? mask_log[0] : -1, 0);
    chk("mask_addr1", mask_log.size() > 1 ? mask_log[1] : -1, 1);

    mlist = '{16'hFFFF, 16'h00FF};
    set_stream(8'h30, 24);
    load(2);
    decoded_ready = 0;
    kick(2);
    for (c = 0; c < 200 && !decoded_valid; c++) @(negedge clk);
    if (c == 200) chk("bp_valid_timeout", 1, 0);
    r0 = act_reads + mask_reads;
    repeat (5) @(posedge clk);
    #1 chk("bp_no_reads", act_reads + mask_reads, r0);
    chk("bp_still_valid", decoded_valid, 1);
    decoded_ready = 1;
    finish_run(2, "bp");
    chk("bp_w1_lit", got_q.size() > 1 ? got_q[1] : 'x, 128'h00000000000000004041424344454647);

    load(0);
    kick(0);
    @(negedge clk);
    chk("zero_nb_done", done_unpacker, 1);
    @(negedge clk);
    chk("zero_nb_done_low", done_unpacker, 0);
    chk("zero_nb_reads", act_reads + mask_reads, 0);

    mlist = '{16'hFFFF};
    set_stream(8'hC0, 16);
    load(1);
    kick(1);
    for (c = 0; c < 200 && !read_act_memory; c++) @(negedge clk);
    if (c == 200) chk("rst_mid_timeout", 1, 0);
    @(posedge clk); #1;
    arst_n = 0;
    #1;
    chk("mid_rst_outs", {read_masks_memory, read_act_memory, decoded_valid, done_unpacker}, 0);
    chk("mid_rst_data", decoded_out, 0);
    chk("mid_rst_addrs", {masks_addr, act_addr}, 0);
    repeat (2) @(negedge clk);
    arst_n = 1;
    mlist = '{16'hFFFF};
    set_stream(0, 16);
    run(1, "after_rst");
    chk("after_rst_lit", got_q.size() > 0 ? got_q[0] : 'x, 128'h000102030405060708090a0b0c0d0e0f);
    chk("after_rst_act_addr", act_log.size() > 0 ? act_log[0] : -1, 0);
    chk("after_rst_mask_addr", mask_log.size() > 0 ? mask_log[0] : -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
endmodule

// File: doc/unpacker.md
UNPACKER -- requirements
Module: unpacker

Interface
REQ-001 The block SHALL have parameter MEM_BW, default 128, giving the memory word width in bits (16 byte lanes).
REQ-002 The block SHALL have parameter ADDR_WIDTH_ACT, default 14, giving the activation memory address width.
REQ-003 The block SHALL have parameter ADDR_WIDTH_MASKS, default 11, giving the mask memory address width.
REQ-004 The block SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-005 The block SHALL have port arst_n_in  input  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have port start_unpacker  input  1  start pulse, sampled only in IDLE.
REQ-007 The block SHALL have port nb_words  input  16  number of decoded words to produce, latched on start.
REQ-008 The block SHALL have port read_masks_memory  output  1  mask memory read strobe.
REQ-009 The block SHALL have port masks_addr  output  ADDR_WIDTH_MASKS  mask memory read address.
REQ-010 The block SHALL have port masks_rdata  input  MEM_BW  mask memory data, valid the cycle after the strobe.
REQ-011 The block SHALL have port read_act_memory  output  1  activation memory read strobe.
REQ-012 The block SHALL have port act_addr  output  ADDR_WIDTH_ACT  activation memory read address.
REQ-013 The block SHALL have port act_rdata  input  MEM_BW  packed activation data, valid the cycle after the strobe.
REQ-014 The block SHALL have port decoded_out  output  MEM_BW  reconstructed 16-byte word.
REQ-015 The block SHALL have port decoded_valid  output  1  decoded_out is valid.
REQ-016 The block SHALL have port decoded_ready  input  1  consumer accepts decoded_out.
REQ-017 The block SHALL have port done_unpacker  output  1  one-cycle pulse when all nb_words are delivered.

Function
REQ-018 A mask word SHALL hold 8 masks of 16 bits each; mask j occupies bits [MEM_BW-1-16j : MEM_BW-16-16j], j=0..7, and masks are used in ascending j order.
REQ-019 Mask bit (15-b) SHALL correspond to output byte lane b, where lane b is bits [MEM_BW-1-8b : MEM_BW-8-8b].
REQ-020 Packed bytes SHALL be consumed in stream order, with lane 0 of each act word first.
REQ-021 The block SHALL hold a 32-byte stream buffer and a 6-bit fill count (0..32); an act word read SHALL append its 16 bytes at position fill in the cycle its data is valid.
REQ-022 For the current mask, need = popcount(mask) (0..16); lane b SHALL be buffer[popcount of mask bits 15..16-b] when mask bit (15-b)=1, else 8'h00.
REQ-023 The FSM SHALL use states IDLE, RD_MASK, WAIT_MASK, CHECK, RD_ACT, WAIT_ACT, OUTPUT, DONE.
REQ-024 IDLE: on start_unpacker=1, latch nb_words, clear counters/fill/addresses; if nb_words=0 go to DONE, else go to RD_MASK.
REQ-025 RD_MASK: assert read_masks_memory for 1 cycle, then WAIT_MASK; WAIT_MASK: latch masks_rdata, set mask index 0, increment masks_addr, go to CHECK.
REQ-026 CHECK: if fill>=need go to OUTPUT, else go to RD_ACT; fill<need implies fill<=15, so an append never overflows 32.
REQ-027 RD_ACT: assert read_act_memory for 1 cycle, then WAIT_ACT; WAIT_ACT: append act_rdata, fill+=16, increment act_addr, go to CHECK.
REQ-028 OUTPUT: assert decoded_valid with a stable decoded_out until decoded_ready=1.
REQ-029 On the OUTPUT handshake: shift the buffer left by need bytes (zero-fill), fill-=need, words_done+=1, mask index+=1.
REQ-030 After the OUTPUT handshake: if words_done=nb_words go to DONE; else if mask index wrapped past 7 go to RD_MASK; else go to CHECK.
REQ-031 DONE: assert done_unpacker for exactly 1 cycle, then go to IDLE.
REQ-032 A mask of 16'h0000 SHALL produce an all-zero word with no act read; a mask of 16'hFFFF with fill=0 SHALL need exactly one act read.
REQ-033 masks_addr and act_addr SHALL wrap modulo 2^width; leftover buffer bytes at DONE SHALL be discarded.
REQ-034 start_unpacker SHALL be ignored outside IDLE; read strobes SHALL never both be high in the same cycle.

Reset
REQ-035 While arst_n_in=0, state SHALL be IDLE and all outputs, counters, addresses, fill and buffer SHALL be 0, including when reset is asserted mid-operation.

Verification
REQ-036 Single all-ones word: nb_words=1, mask0=16'hFFFF, act word 0x00..0F -> decoded_out=0x000102..0F, one act read, done pulse.
REQ-037 Zero mask: nb_words=1, mask 16'h0000 -> decoded_out=0, read_act_memory never asserted.
REQ-038 Word straddle: masks 16'hFF00, 16'hFFF0, 16'hFF00 -> 8+12+8 bytes decoded; the second word spans act words 0/1; exactly 2 act reads.
REQ-039 Mask word boundary: nb_words=9 -> two mask reads at addresses 0,1; the 9th word uses mask j=0 of the second mask word.
REQ-040 Backpressure: decoded_ready=0 for 5 cycles in OUTPUT -> decoded_out stable and no extra reads; nb_words=0 -> done_unpacker 1 cycle after start.
REQ-041 Reset during WAIT_ACT -> all outputs 0 next cycle; a fresh start decodes correctly from address 0.
